// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle M-extension unit that sits beside the single-cycle ALU in EX.
//   Handles MUL (7), MULH (8), DIV (9) and REM (10) with a shift-add multiplier
//   and a restoring divider. Each runs XLEN iterations on operand magnitudes,
//   and the sign is applied in a final fix-up cycle. The pipeline is held via
//   stall until the result is ready. A flush aborts the operation in flight.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   start   EX requests an M-op this cycle
//   op      ALU selector code (only 7/8/9/10 are accepted)
//   a, b    rs1 / rs2 operands (after forwarding)
//   flush   pipeline nop/branch flush; aborts the op in flight
//   stall   freeze PC and IF/ID/EX registers
//   busy    sequencer not IDLE
//   done    one-cycle pulse, result valid
//   result  product / quotient / remainder; held until the next result
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   localparam logic [3:0] OP_MUL  = 4'd7;
   localparam logic [3:0] OP_MULH = 4'd8;
   localparam logic [3:0] OP_DIV  = 4'd9;
   localparam logic [3:0] OP_REM  = 4'd10;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   function automatic logic [XLEN-1:0] abs_x(input logic signed [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      // -2^(XLEN-1) maps to its unsigned magnitude 2^(XLEN-1)
      r = v[XLEN-1] ? (~v + XLEN'(1)) : v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
      return ~v + XLEN'(1);
   endfunction

   function automatic logic [2*XLEN-1:0] neg_w(input logic [2*XLEN-1:0] v);
      return ~v + (2*XLEN)'(1);
   endfunction

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [3:0]          op_q;
   logic                neg_q;   // product / quotient must be negated
   logic                neg_r;   // remainder must be negated (sign of a)
   logic                dz;      // divide by zero captured
   logic [XLEN-1:0]     m_q;     // multiplicand (mul) or divisor (div) magnitude
   logic [2*XLEN-1:0]   acc;     // mul: {hi, multiplier}; div: {rem, quot}

   logic                op_ok;
   logic                op_div;
   logic                accept;
   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       rem_sh;
   logic [XLEN:0]       trial;
   logic [XLEN-1:0]     quot_sh;
   logic [2*XLEN-1:0]   mul_next;
   logic [2*XLEN-1:0]   div_next;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     fix_val;

   assign op_ok  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign op_div = (op == OP_DIV) || (op == OP_REM);
   assign accept = (state == IDLE) && start && op_ok && !flush;

   // ---- iteration datapath (one shift-add or restoring step per RUN cycle) ----
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_q} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};

      // {rem, quot} << 1: the top XLEN+1 bits form the partial remainder
      rem_sh   = acc[2*XLEN-1:XLEN-1];
      quot_sh  = {acc[XLEN-2:0], 1'b0};
      trial    = rem_sh - {1'b0, m_q};
      div_next = trial[XLEN] ? {rem_sh[XLEN-1:0], quot_sh}
                             : {trial[XLEN-1:0], quot_sh[XLEN-1:1], 1'b1};
   end

   // ---- fix-up: sign correction and output select ----
   always_comb begin
      prod    = neg_q ? neg_w(acc) : acc;
      fix_val = '0;
      case (op_q)
         OP_MUL:  fix_val = prod[XLEN-1:0];
         OP_MULH: fix_val = prod[2*XLEN-1:XLEN];
         OP_DIV:  fix_val = dz ? '1 : (neg_q ? neg_x(acc[XLEN-1:0]) : acc[XLEN-1:0]);
         OP_REM: begin
            // on divide by zero the low half still holds |a|, so this rebuilds a
            if (dz)
               fix_val = neg_r ? neg_x(acc[XLEN-1:0]) : acc[XLEN-1:0];
            else
               fix_val = neg_r ? neg_x(acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
         end
         default: fix_val = '0;
      endcase
   end

   // ---- sequencer control ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q  <= op;
                  neg_q <= a[XLEN-1] ^ b[XLEN-1];
                  neg_r <= a[XLEN-1];
                  dz    <= op_div && (b == '0);
                  cnt   <= CNT_W'(XLEN);
                  state <= (op_div && (b == '0)) ? FIX : RUN;
               end
            end
            RUN: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1))
                     state <= FIX;
               end
            end
            FIX: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  result <= fix_val;
                  state  <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ---- operand capture and iteration registers (no reset needed) ----
   always_ff @(posedge clk) begin
      if (accept) begin
         if (op_div) begin
            acc <= {{XLEN{1'b0}}, abs_x(a)};
            m_q <= abs_x(b);
         end else begin
            acc <= {{XLEN{1'b0}}, abs_x(b)};
            m_q <= abs_x(a);
         end
      end else if (state == RUN) begin
         acc <= (op_q == OP_DIV || op_q == OP_REM) ? div_next : mul_next;
      end
   end

   assign busy  = (state != IDLE);
   assign done  = (state == DONE) && !flush;
   assign stall = !flush && ((state == IDLE && start && op_ok) || state == RUN || state == FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          vec_cnt;
   int          err_cnt;
   logic [31:0] exp_q[$];
   logic [31:0] last_res;
   logic [31:0] mon_exp;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model built from native signed arithmetic.
   function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] p;
      p = 64'($signed(x)) * 64'($signed(y));
      case (o)
         4'd7:  return p[31:0];
         4'd8:  return p[63:32];
         4'd9: begin
            if (y == 32'd0) return 32'hFFFFFFFF;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
            return $signed(x) / $signed(y);
         end
         4'd10: begin
            if (y == 32'd0) return x;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
            return $signed(x) % $signed(y);
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from an IDLE cycle; checks latency, stall cycles and return to IDLE.
   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int exp_lat);
      int lat;
      int scnt;
      exp_q.push_back(model(o, x, y));
      start = 1'b1; op = o; a = x; b = y;
      #1;
      scnt = int'(stall);
      lat  = 0;
      for (int n = 1; n <= 60; n++) begin
         step();
         if (n == 1) begin
            start = 1'b0;
            op = 4'($urandom);
            a  = $urandom;
            b  = $urandom;
         end
         #1;
         if (stall) scnt++;
         if (done) begin
            lat = n;
            break;
         end
      end
      chk($sformatf("latency_op%0d", o), lat, exp_lat);
      chk($sformatf("stall_cycles_op%0d", o), scnt, exp_lat);
      step();
      #1;
      chk("idle_after_done", busy, 1'b0);
   endtask

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("result", result, mon_exp);
            last_res = mon_exp;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected 0 pending");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [3:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;
      vec_cnt  = 0;
      err_cnt  = 0;
      last_res = 32'd0;
      rst = 1'b0; start = 1'b0; flush = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
      #1 rst = 1'b1;
      #2;
      chk("reset_stall",  stall,  1'b0);
      chk("reset_busy",   busy,   1'b0);
      chk("reset_done",   done,   1'b0);
      chk("reset_result", result, 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // invalid op is ignored
      start = 1'b1; op = 4'd2; a = 32'd3; b = 32'd4;
      #1;
      chk("invalid_stall", stall, 1'b0);
      step();
      #1;
      chk("invalid_busy", busy, 1'b0);
      // valid op together with flush is ignored
      op = 4'd7; flush = 1'b1;
      #1;
      chk("flushreq_stall", stall, 1'b0);
      step();
      start = 1'b0; flush = 1'b0;
      #1;
      chk("flushreq_busy", busy, 1'b0);

      // directed vectors
      run_op(4'd7,  32'd7,        32'hFFFFFFFD, 34);
      run_op(4'd8,  32'h80000000, 32'h80000000, 34);
      run_op(4'd8,  32'hFFFFFFFF, 32'd1,        34);
      run_op(4'd9,  32'hFFFFFFF9, 32'd2,        34);
      run_op(4'd10, 32'hFFFFFFF9, 32'd2,        34);
      run_op(4'd9,  32'h80000000, 32'hFFFFFFFF, 34);
      run_op(4'd10, 32'h80000000, 32'hFFFFFFFF, 34);
      run_op(4'd9,  32'd5,        32'd0,        2);
      run_op(4'd10, 32'd5,        32'd0,        2);
      run_op(4'd10, 32'hFFFFFFFB, 32'd0,        2);

      // flush in RUN cycle 10: no done, result kept, stall low in flush cycle
      start = 1'b1; op = 4'd9; a = 32'd100; b = 32'd7;
      step();
      start = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      #1;
      chk("flush_run_stall", stall, 1'b0);
      chk("flush_run_done",  done,  1'b0);
      step();
      flush = 1'b0;
      #1;
      chk("flush_run_busy",   busy,   1'b0);
      chk("flush_run_result", result, last_res);
      repeat (40) step();

      // flush in the DONE cycle suppresses done
      start = 1'b1; op = 4'd7; a = 32'd3; b = 32'd5;
      step();
      start = 1'b0;
      repeat (33) step();
      flush = 1'b1;
      #1;
      chk("flush_done_pulse", done, 1'b0);
      chk("flush_done_busy",  busy, 1'b1);
      step();
      flush = 1'b0;
      #1;
      chk("flush_done_idle", busy, 1'b0);

      // asynchronous reset mid-RUN
      start = 1'b1; op = 4'd10; a = 32'd1000; b = 32'd13;
      step();
      start = 1'b0;
      repeat (5) step();
      #1 rst = 1'b1;
      #1;
      chk("arst_stall",  stall,  1'b0);
      chk("arst_busy",   busy,   1'b0);
      chk("arst_done",   done,   1'b0);
      chk("arst_result", result, 32'd0);
      last_res = 32'd0;
      step();
      rst = 1'b0;
      step();
      repeat (40) step();

      // back-to-back: MUL, start held from its DONE cycle launches DIV next IDLE cycle
      exp_q.push_back(model(4'd7, 32'h00012345, 32'hFFFF0003));
      start = 1'b1; op = 4'd7; a = 32'h00012345; b = 32'hFFFF0003;
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         step();
         if (n == 1) start = 1'b0;
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      chk("b2b_mul_latency", lat, 34);
      start = 1'b1; op = 4'd9; a = 32'hFFFF8000; b = 32'd123;
      #1;
      chk("b2b_stall_in_done", stall, 1'b0);
      step();
      #1;
      chk("b2b_idle_busy", busy,  1'b0);
      chk("b2b_req_stall", stall, 1'b1);
      run_op(4'd9, 32'hFFFF8000, 32'd123, 34);

      // random vectors, including small divisors and zero divisors
      for (int i = 0; i < 8; i++) begin
         ro = 4'd7 + 4'($urandom_range(0, 3));
         rx = $urandom;
         if (i % 3 == 0)      ry = 32'd0;
         else if (i % 2 == 1) ry = $urandom_range(1, 50);
         else                 ry = $urandom;
         lat = (ro >= 4'd9 && ry == 32'd0) ? 2 : 34;
         run_op(ro, rx, ry, lat);
      end

      repeat (3) step();
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
